// File: rtl/svk_ahb_pkg.sv
// ============================================================================
// svk_ahb_pkg
// Shared AHB encodings (HTRANS, HSIZE, HRESP) and the response FSM state type
// used by svk_ahb_slave_rsp.
// Optional feature macro: SVK_AHB_SLAVE_RSP_ERR_EN adds the ERR1/ERR2 states.
// ============================================================================
package svk_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'b000;
    localparam logic [2:0] HSIZE_HWORD = 3'b001;
    localparam logic [2:0] HSIZE_WORD  = 3'b010;
    localparam logic [2:0] HSIZE_DWORD = 3'b011;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1
`ifdef SVK_AHB_SLAVE_RSP_ERR_EN
        ,
        ERR1 = 2'd2,
        ERR2 = 2'd3
`endif
    } state_t;

endpackage

// File: rtl/svk_ahb_slave_mem.sv
// ============================================================================
// svk_ahb_slave_mem
// Single-port byte-enable RAM, MEM_DEPTH x DATA_WIDTH. Synchronous write,
// combinational read, no reset of contents.
// Ports:
//   i_clk    clock
//   i_we     write enable
//   i_be     byte-lane enables (DATA_WIDTH/8)
//   i_idx    word index
//   i_wdata  write data
//   o_rdata  read data of word i_idx (combinational)
// ============================================================================
module svk_ahb_slave_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                         i_clk,
    input  logic                         i_we,
    input  logic [DATA_WIDTH/8-1:0]      i_be,
    input  logic [$clog2(MEM_DEPTH)-1:0] i_idx,
    input  logic [DATA_WIDTH-1:0]        i_wdata,
    output logic [DATA_WIDTH-1:0]        o_rdata
);

    localparam int NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < NB; b++) begin
                if (i_be[b]) begin
                    r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/svk_ahb_slave_rsp.sv
// ============================================================================
// svk_ahb_slave_rsp
// AHB slave responder backed by a byte-enable RAM. Supports pipelined
// back-to-back transfers, WAIT_CYCLES wait states per OKAY transfer, and
// (optionally) a two-cycle ERROR response.
// Optional feature macro: SVK_AHB_SLAVE_RSP_ERR_EN
//   defined   : out-of-range word index or oversize hsize -> ERR1, ERR2
//   undefined : hresp tied OKAY, addresses wrap, oversize hsize truncated
// Ports:
//   hclk, hresetn           clock, asynchronous active-low reset
//   hsel, haddr, htrans,    address-phase inputs
//   hwrite, hsize
//   hwdata                  write data (data phase)
//   hready                  bus HREADY
//   hreadyout, hresp,       slave response
//   hrdata
// ============================================================================
module svk_ahb_slave_rsp
    import svk_ahb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_CYCLES = 0
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic                  hsel,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [1:0]            htrans,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [DATA_WIDTH-1:0] hwdata,
    input  logic                  hready,
    output logic                  hreadyout,
    output logic                  hresp,
    output logic [DATA_WIDTH-1:0] hrdata
);

    localparam int NB     = DATA_WIDTH / 8;
    localparam int LANE_W = $clog2(NB);
    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam int AW     = IDX_W + LANE_W;

    state_t                r_state, w_state_nxt;
    logic [3:0]            r_cnt, w_cnt_nxt;
    logic                  r_dphase, w_dphase_nxt;
    logic [AW-1:0]         r_addr;
    logic                  r_write;
    logic [2:0]            r_size;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [DATA_WIDTH-1:0] w_mem_rdata;
    logic                  w_accept;
    logic                  w_ready;
    logic                  w_complete;
    logic                  w_mem_we;
    logic [NB-1:0]         w_be;
    logic                  w_unused;

    // Byte lanes touched by a transfer; sizes wider than the bus cover all lanes.
    function automatic logic [NB-1:0] f_byte_en(input logic [2:0] size,
                                                input logic [LANE_W-1:0] off);
        int n;
        int base;
        n    = 1 << ((int'(size) > LANE_W) ? LANE_W : int'(size));
        base = (int'(off) / n) * n;
        for (int b = 0; b < NB; b++) begin
            f_byte_en[b] = (b >= base) && (b < base + n);
        end
    endfunction

    assign w_accept = hsel & hready & htrans[1];

    // Upper address bits only matter to the range check; htrans[0] never does.
    assign w_unused = ^{htrans[0], haddr};

`ifdef SVK_AHB_SLAVE_RSP_ERR_EN
    logic w_err;
    logic w_resp;
    assign w_err = ((haddr >> LANE_W) >= ADDR_WIDTH'(MEM_DEPTH)) || (int'(hsize) > LANE_W);
    assign hresp = w_resp;
`else
    assign hresp = HRESP_OKAY;
`endif

    // A data phase completes in IDLE with a pending transfer; WAIT hands over
    // to IDLE after its last low cycle so completion is always in one place.
    assign w_complete = (r_state == IDLE) && r_dphase;
    assign w_mem_we   = w_complete & r_write;
    assign w_be       = f_byte_en(r_size, r_addr[LANE_W-1:0]);
    assign hreadyout  = w_ready;
    assign hrdata     = (w_complete && !r_write) ? w_mem_rdata : r_rdata;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_dphase_nxt = r_dphase;
        w_ready      = 1'b1;
`ifdef SVK_AHB_SLAVE_RSP_ERR_EN
        w_resp       = HRESP_OKAY;
`endif
        case (r_state)
            WAIT: begin
                w_ready = 1'b0;
                if (r_cnt <= 4'd1) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
`ifdef SVK_AHB_SLAVE_RSP_ERR_EN
            ERR1: begin
                w_ready     = 1'b0;
                w_resp      = HRESP_ERROR;
                w_state_nxt = ERR2;
            end
            ERR2: begin
                w_resp      = HRESP_ERROR;
                w_state_nxt = IDLE;
            end
`endif
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Address phases are taken only in a cycle where this slave is ready,
        // which is also the final cycle of any transfer in flight.
        if (w_ready) begin
            w_dphase_nxt = 1'b0;
            if (w_accept) begin
`ifdef SVK_AHB_SLAVE_RSP_ERR_EN
                if (w_err) begin
                    w_state_nxt = ERR1;
                end else
`endif
                if (WAIT_CYCLES > 0) begin
                    w_state_nxt  = WAIT;
                    w_cnt_nxt    = 4'(WAIT_CYCLES);
                    w_dphase_nxt = 1'b1;
                end else begin
                    w_state_nxt  = IDLE;
                    w_dphase_nxt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state  <= IDLE;
            r_cnt    <= 4'd0;
            r_dphase <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_dphase <= w_dphase_nxt;
            r_rdata  <= hrdata;
        end
    end

    always_ff @(posedge hclk) begin
        if (w_ready && w_accept) begin
            r_addr  <= haddr[AW-1:0];
            r_write <= hwrite;
            r_size  <= hsize;
        end
    end

    svk_ahb_slave_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_mem (
        .i_clk   (hclk),
        .i_we    (w_mem_we),
        .i_be    (w_be),
        .i_idx   (r_addr[AW-1:LANE_W]),
        .i_wdata (hwdata),
        .o_rdata (w_mem_rdata)
    );

endmodule

// File: tb/tb_svk_ahb_slave_rsp.sv
// ============================================================================
// tb_svk_ahb_slave_rsp
// Two responders (WAIT_CYCLES=0 and WAIT_CYCLES=3) share one set of driven
// bus signals; hsel is steered to the one under test by 'cur'.
// Honours SVK_AHB_SLAVE_RSP_ERR_EN to decide the expected error behaviour.
// ============================================================================
module tb_svk_ahb_slave_rsp;
    import svk_ahb_pkg::*;

`ifdef SVK_AHB_SLAVE_RSP_ERR_EN
    localparam bit ERR_BUILD = 1'b1;
`else
    localparam bit ERR_BUILD = 1'b0;
`endif

    logic        hclk;
    logic        hresetn;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    int          cur;

    logic        hsel0, hsel1;
    logic        ro0, ro1, rsp0, rsp1;
    logic [31:0] rd0, rd1;
    logic        w_ro, w_rsp;
    logic [31:0] w_rd;

    int n_cmp;
    int n_bad;

    logic [31:0] mdl [2][256];

    assign hsel0 = hsel && (cur == 0);
    assign hsel1 = hsel && (cur == 1);
    assign w_ro  = (cur == 0) ? ro0  : ro1;
    assign w_rsp = (cur == 0) ? rsp0 : rsp1;
    assign w_rd  = (cur == 0) ? rd0  : rd1;

    svk_ahb_slave_rsp #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_CYCLES(0)) u_dut0 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(ro0),
        .hreadyout(ro0), .hresp(rsp0), .hrdata(rd0)
    );

    svk_ahb_slave_rsp #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(256), .WAIT_CYCLES(3)) u_dut3 (
        .hclk(hclk), .hresetn(hresetn), .hsel(hsel1), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hwdata(hwdata), .hready(ro1),
        .hreadyout(ro1), .hresp(rsp1), .hrdata(rd1)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference write: byte lanes from size and offset, sizes above a word
    // cover the whole word, word index wraps at 256.
    task automatic model_write(input int d, input logic [31:0] addr,
                               input logic [2:0] size, input logic [31:0] data);
        int n, off, base, idx;
        n    = (size > 3'd2) ? 4 : (1 << size);
        off  = int'(addr % 4);
        base = off - (off % n);
        idx  = int'((addr / 4) % 256);
        for (int b = base; b < base + n; b++) begin
            mdl[d][idx][8*b +: 8] = data[8*b +: 8];
        end
    endtask

    task automatic xfer(input bit wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic resp, output int lows, output logic low_resp);
        bit done;
        done     = 1'b0;
        lows     = 0;
        low_resp = 1'b0;
        rdata    = 'x;
        resp     = 'x;
        @(posedge hclk); #1;
        hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = addr; hwrite = wr; hsize = size;
        @(posedge hclk); #1;
        hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = wdata;
        for (int k = 0; k < 40; k++) begin
            @(negedge hclk);
            if (w_ro === 1'b1) begin
                rdata = w_rd;
                resp  = w_rsp;
                done  = 1'b1;
                break;
            end
            lows++;
            low_resp = w_rsp;
            @(posedge hclk);
        end
        if (!done) chk("xfer_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_op(input int d, input bit wr, input logic [31:0] addr,
                         input logic [2:0] size, input logic [31:0] data, input string tag);
        logic [31:0] rdata;
        logic        resp, low_resp;
        int          lows;
        bit          err_exp;
        cur     = d;
        err_exp = ERR_BUILD && (((addr >> 2) >= 256) || (size > 3'd2));
        xfer(wr, addr, size, data, rdata, resp, lows, low_resp);
        chk({tag, "_resp"}, 64'(resp), 64'(err_exp));
        chk({tag, "_lows"}, 64'(lows), err_exp ? 64'd1 : ((d == 1) ? 64'd3 : 64'd0));
        if (err_exp) begin
            chk({tag, "_err1_resp"}, 64'(low_resp), 64'd1);
        end else if (wr) begin
            model_write(d, addr, size, data);
        end else begin
            chk({tag, "_rdata"}, 64'(rdata), 64'(mdl[d][int'((addr / 4) % 256)]));
        end
    endtask

    initial begin
        logic [31:0] rnd_data;
        logic [2:0]  rnd_size;
        int          rnd_idx, rnd_off;
        bit          rnd_wr;

        n_cmp = 0; n_bad = 0; cur = 0;
        hresetn = 1'b0; hsel = 1'b0; haddr = '0; htrans = HTRANS_IDLE;
        hwrite = 1'b0; hsize = HSIZE_WORD; hwdata = '0;

        // Reset values on both responders
        repeat (3) @(posedge hclk);
        #1;
        chk("rst_ro0", 64'(ro0), 64'd1);
        chk("rst_rsp0", 64'(rsp0), 64'd0);
        chk("rst_rd0", 64'(rd0), 64'd0);
        chk("rst_ro1", 64'(ro1), 64'd1);
        chk("rst_rsp1", 64'(rsp1), 64'd0);
        chk("rst_rd1", 64'(rd1), 64'd0);
        @(negedge hclk);
        hresetn = 1'b1;

        // Back-to-back write then read of 0x10, zero wait states
        cur = 0;
        @(posedge hclk); #1;
        hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h10; hwrite = 1'b1; hsize = HSIZE_WORD;
        @(posedge hclk); #1;
        hwdata = 32'hDEADBEEF; hwrite = 1'b0;
        @(negedge hclk);
        chk("b2b_wr_ready", 64'(w_ro), 64'd1);
        @(posedge hclk); #1;
        hsel = 1'b0; htrans = HTRANS_IDLE;
        model_write(0, 32'h10, HSIZE_WORD, 32'hDEADBEEF);
        @(negedge hclk);
        chk("b2b_rd_ready", 64'(w_ro), 64'd1);
        chk("b2b_rd_data", 64'(w_rd), 64'hDEADBEEF);
        @(negedge hclk);
        chk("rdata_hold", 64'(w_rd), 64'hDEADBEEF);

        // Byte write into an existing word
        do_op(0, 1'b1, 32'h10, HSIZE_WORD, 32'h11223344, "w10");
        do_op(0, 1'b1, 32'h13, HSIZE_BYTE, 32'hAB000000, "wb13");
        do_op(0, 1'b0, 32'h10, HSIZE_WORD, 32'h0, "rb10");
        chk("byte_model", 64'(mdl[0][4]), 64'hAB223344);

        // Wait states on the WAIT_CYCLES=3 responder
        do_op(1, 1'b1, 32'h20, HSIZE_WORD, 32'h600DCAFE, "w3_wr");
        do_op(1, 1'b0, 32'h20, HSIZE_WORD, 32'h0, "w3_rd");

        // BUSY and IDLE with hsel=1 between transfers: zero-wait OKAY, no access
        cur = 0;
        @(posedge hclk); #1;
        hsel = 1'b1; htrans = HTRANS_BUSY; haddr = 32'h10; hwrite = 1'b1; hsize = HSIZE_WORD;
        @(posedge hclk); #1;
        hwdata = 32'hFFFFFFFF; htrans = HTRANS_IDLE;
        @(negedge hclk);
        chk("busy_ro", 64'(w_ro), 64'd1);
        chk("busy_rsp", 64'(w_rsp), 64'd0);
        chk("busy_rd_hold", 64'(w_rd), 64'hAB223344);
        @(posedge hclk); #1;
        hsel = 1'b0;
        do_op(0, 1'b0, 32'h10, HSIZE_WORD, 32'h0, "busy_rb");

        // Oversize hsize and out-of-range address
        do_op(0, 1'b1, 32'h18, HSIZE_WORD, 32'h01020304, "w18");
        do_op(0, 1'b1, 32'h18, HSIZE_DWORD, 32'hCAFEF00D, "dw18");
        do_op(0, 1'b0, 32'h18, HSIZE_WORD, 32'h0, "rb18");
        do_op(0, 1'b1, 32'h0, HSIZE_WORD, 32'h5A5A1234, "w0");
        do_op(0, 1'b1, 32'h400, HSIZE_WORD, 32'h0BADF00D, "w400");
        do_op(0, 1'b0, 32'h0, HSIZE_WORD, 32'h0, "rb0");
        do_op(1, 1'b1, 32'h0, HSIZE_WORD, 32'h77665544, "w3_0");
        do_op(1, 1'b1, 32'h800, HSIZE_WORD, 32'h12345678, "w3_800");
        do_op(1, 1'b0, 32'h0, HSIZE_WORD, 32'h0, "w3_rb0");

        // Reset during a WAIT-state write aborts it
        do_op(1, 1'b1, 32'h24, HSIZE_WORD, 32'h13572468, "w24");
        cur = 1;
        @(posedge hclk); #1;
        hsel = 1'b1; htrans = HTRANS_NONSEQ; haddr = 32'h24; hwrite = 1'b1; hsize = HSIZE_WORD;
        @(posedge hclk); #1;
        hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'hFFFF0000;
        @(negedge hclk);
        chk("midrst_wait_low", 64'(w_ro), 64'd0);
        #2;
        hresetn = 1'b0;
        #1;
        chk("midrst_ro", 64'(w_ro), 64'd1);
        chk("midrst_rsp", 64'(w_rsp), 64'd0);
        chk("midrst_rd", 64'(w_rd), 64'd0);
        @(posedge hclk);
        @(negedge hclk);
        hresetn = 1'b1;
        do_op(1, 1'b0, 32'h24, HSIZE_WORD, 32'h0, "midrst_rb");

        // Randomized traffic against the reference model, both responders
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) begin
                do_op(d, 1'b1, 32'(i * 4), HSIZE_WORD, $urandom, "init");
            end
            for (int i = 0; i < 40; i++) begin
                rnd_idx  = $urandom_range(0, 15);
                rnd_size = 3'($urandom_range(0, 2));
                rnd_off  = $urandom_range(0, 3);
                rnd_off  = rnd_off - (rnd_off % (1 << rnd_size));
                rnd_wr   = 1'($urandom_range(0, 1));
                rnd_data = $urandom;
                do_op(d, rnd_wr, 32'(rnd_idx * 4 + rnd_off), rnd_size, rnd_data, "rnd");
            end
            for (int i = 0; i < 16; i++) begin
                do_op(d, 1'b0, 32'(i * 4), HSIZE_WORD, 32'h0, "final_rd");
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
